// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Shares one external 16-bit adder between two requesters. A round-robin
// grant picks a requester in IDLE. Its operands are latched. The adder runs in
// EXEC, and the sum is held in RESP until the owner takes it.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   reqN_valid/ready                 operation handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_sub         operands; sub selects A - B
//   add_a, add_b, add_cin            drive the shared external adder
//   add_r                            combinational sum from the adder
//   resN_valid/ready                 result handshake (N = 0, 1)
//   res_data                         result word shared by both channels
module adder_share_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_sub,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_r,
  output logic        res0_valid,
  input  logic        res0_ready,
  output logic        res1_valid,
  input  logic        res1_ready,
  output logic [15:0] res_data
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;    // requester served most recently
  logic        owner_q, owner_d;  // requester owning the in-flight operation
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic        cin_q, cin_d;
  logic [15:0] res_q, res_d;

  logic grant0, grant1, accept, owner_ready;

  // req1 wins when it is alone, or when both are valid and req0 was served last.
  assign grant1 = req1_valid & (~req0_valid | ~last_q);
  assign grant0 = req0_valid & ~grant1;

  assign accept      = (state_q == StIdle) & rst_n & (req0_valid | req1_valid);
  assign owner_ready = owner_q ? res1_ready : res0_ready;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cin_d   = cin_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d = grant1;
          last_d  = grant1;
          op_a_d  = grant1 ? req1_a : req0_a;
          // Subtraction is A + ~B + 1, so invert B and use sub as carry-in.
          op_b_d  = grant1 ? (req1_sub ? ~req1_b : req1_b)
                           : (req0_sub ? ~req0_b : req0_b);
          cin_d   = grant1 ? req1_sub : req0_sub;
          state_d = StExec;
        end
      end
      StExec: begin
        res_d   = add_r;
        state_d = StResp;
      end
      StResp: begin
        if (owner_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      op_a_q  <= 16'h0000;
      op_b_q  <= 16'h0000;
      cin_q   <= 1'b0;
      res_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
    end
  end

  // The adder inputs come straight from the latched registers. They change only
  // on an accept, so they hold steady in IDLE and RESP.
  assign add_a   = op_a_q;
  assign add_b   = op_b_q;
  assign add_cin = cin_q;

  assign req0_ready = (state_q == StIdle) & rst_n & grant0;
  assign req1_ready = (state_q == StIdle) & rst_n & grant1;
  assign res0_valid = (state_q == StResp) & ~owner_q;
  assign res1_valid = (state_q == StResp) & owner_q;
  assign res_data   = res_q;

endmodule
